// File: rtl/hist_pkg.sv
// Shared definitions for the histogram readout scheduler: default geometry,
// FSM state encoding and the stream word layout.
package hist_pkg;

   localparam int unsigned NCH_DEF    = 64;
   localparam int unsigned NWORDS_DEF = 8;
   localparam int unsigned RD_LAT_DEF = 3;

   typedef enum logic [2:0] {
      IDLE,
      SEL,
      CAP,
      STREAM,
      DONE,
      CLR
   } state_t;

   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  chan;
      logic [2:0]  idx;
      logic        last;
   } stream_word_t;

endpackage

// File: rtl/hist_auto_timer.sv
// Periodic auto-scan tick generator: counts clk_adc cycles while enabled and
// pulses tick once every auto_period cycles.
module hist_auto_timer (
   input  logic        clk_adc,
   input  logic        rst,
   input  logic        auto_en,
   input  logic [31:0] auto_period,
   output logic        tick
);

   logic [31:0] cnt_q;
   logic [31:0] period_q;
   logic        enabled;
   logic        restart;

   // A changed period is seen one cycle before period_q catches up; the count
   // is forced back to 0 on that cycle and no tick may fire from the stale count.
   always_comb begin
      enabled = auto_en && (auto_period != '0);
      restart = (auto_period != period_q);
      tick    = enabled && !restart && (cnt_q == auto_period - 32'd1);
   end

   always_ff @(posedge clk_adc) begin
      if (rst) begin
         cnt_q    <= '0;
         period_q <= '0;
      end else begin
         period_q <= auto_period;
         if (restart || !enabled || tick) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 32'd1;
         end
      end
   end

endmodule

// File: rtl/hist_readout_sched.sv
// Histogram readout/clear sequencer: selects each channel, waits the select
// latency, snapshots its words and streams them; also steps resethist over all channels.
module hist_readout_sched
   import hist_pkg::*;
#(
   parameter int unsigned NCH    = NCH_DEF,
   parameter int unsigned NWORDS = NWORDS_DEF,
   parameter int unsigned RD_LAT = RD_LAT_DEF
) (
   input  logic                 clk_adc,
   input  logic                 rst,
   input  logic                 scan_start,
   input  logic                 clear_start,
   input  logic                 auto_en,
   input  logic [31:0]          auto_period,
   output logic [7:0]           hist_sel,
   input  logic [NWORDS*32-1:0] hist_in,
   output logic                 resethist,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_data,
   output logic [7:0]           out_chan,
   output logic [2:0]           out_idx,
   output logic                 out_last,
   output logic                 busy,
   output logic [15:0]          scan_count
);

   localparam int unsigned WW        = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [WW-1:0] LAST_WAIT = WW'(RD_LAT - 1);
   localparam logic [7:0]    LAST_CHAN = 8'(NCH - 1);
   localparam logic [2:0]    LAST_IDX  = 3'(NWORDS - 1);

   state_t                  state_q, state_d;
   logic [7:0]              chan_q, chan_d;
   logic [WW-1:0]           wait_q, wait_d;
   logic [2:0]              idx_q, idx_d;
   logic [NWORDS-1:0][31:0] shadow_q;
   logic                    pend_scan_q, pend_scan_d;
   logic                    pend_clr_q, pend_clr_d;
   logic [15:0]             scan_count_q;
   logic                    cap_en;
   logic                    cnt_inc;
   logic                    auto_tick;
   logic                    scan_req, clr_req;
   logic                    take_scan, take_clr;
   stream_word_t            word;

   hist_auto_timer u_auto_timer (
      .clk_adc     (clk_adc),
      .rst         (rst),
      .auto_en     (auto_en),
      .auto_period (auto_period),
      .tick        (auto_tick)
   );

   // Requests arriving this cycle are visible to IDLE immediately, which gives
   // the RD_LAT+2 start latency; anything not taken lands in a one-deep flag.
   always_comb begin
      state_d   = state_q;
      chan_d    = chan_q;
      wait_d    = wait_q;
      idx_d     = idx_q;
      cap_en    = 1'b0;
      cnt_inc   = 1'b0;
      take_scan = 1'b0;
      take_clr  = 1'b0;
      scan_req  = pend_scan_q || scan_start || auto_tick;
      clr_req   = pend_clr_q || clear_start;

      case (state_q)
         IDLE: begin
            chan_d = '0;
            wait_d = '0;
            idx_d  = '0;
            if (clr_req) begin
               take_clr = 1'b1;
               state_d  = CLR;
            end else if (scan_req) begin
               take_scan = 1'b1;
               state_d   = SEL;
            end
         end
         SEL: begin
            if (wait_q == LAST_WAIT) begin
               state_d = CAP;
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end
         CAP: begin
            cap_en  = 1'b1;
            wait_d  = '0;
            idx_d   = '0;
            state_d = STREAM;
         end
         STREAM: begin
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
                  idx_d = '0;
                  if (chan_q == LAST_CHAN) begin
                     chan_d  = '0;
                     state_d = DONE;
                  end else begin
                     chan_d  = chan_q + 8'd1;
                     state_d = SEL;
                  end
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         DONE: begin
            cnt_inc = 1'b1;
            state_d = IDLE;
         end
         CLR: begin
            if (wait_q == LAST_WAIT) begin
               wait_d = '0;
               if (chan_q == LAST_CHAN) begin
                  chan_d  = '0;
                  state_d = IDLE;
               end else begin
                  chan_d = chan_q + 8'd1;
               end
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      pend_scan_d = scan_req && !take_scan;
      pend_clr_d  = clr_req && !take_clr;
   end

   always_ff @(posedge clk_adc) begin
      if (rst) begin
         state_q      <= IDLE;
         chan_q       <= '0;
         wait_q       <= '0;
         idx_q        <= '0;
         shadow_q     <= '0;
         pend_scan_q  <= 1'b0;
         pend_clr_q   <= 1'b0;
         scan_count_q <= '0;
      end else begin
         state_q     <= state_d;
         chan_q      <= chan_d;
         wait_q      <= wait_d;
         idx_q       <= idx_d;
         pend_scan_q <= pend_scan_d;
         pend_clr_q  <= pend_clr_d;
         if (cap_en) begin
            shadow_q <= hist_in;
         end
         if (cnt_inc) begin
            scan_count_q <= scan_count_q + 16'd1;
         end
      end
   end

   always_comb begin
      word.data = shadow_q[idx_q];
      word.chan = chan_q;
      word.idx  = idx_q;
      word.last = (chan_q == LAST_CHAN) && (idx_q == LAST_IDX);

      out_valid  = (state_q == STREAM);
      out_data   = word.data;
      out_chan   = word.chan;
      out_idx    = word.idx;
      out_last   = out_valid && word.last;
      hist_sel   = chan_q;
      resethist  = (state_q == CLR);
      busy       = (state_q != IDLE);
      scan_count = scan_count_q;
   end

endmodule

// File: tb/tb_hist_readout_sched.sv
// Directed bench for hist_readout_sched with a pipelined histogram model
// whose data is only valid RD_LAT cycles after a select change.
module tb_hist_readout_sched;
   import hist_pkg::*;

   localparam int NCH   = 64;
   localparam int NW    = 8;
   localparam int RL    = 3;
   localparam int TOTAL = NCH * NW;

   logic           clk_adc = 1'b0;
   logic           rst;
   logic           scan_start;
   logic           clear_start;
   logic           auto_en;
   logic [31:0]    auto_period;
   logic [7:0]     hist_sel;
   logic [NW*32-1:0] hist_in;
   logic           resethist;
   logic           out_valid;
   logic           out_ready;
   logic [31:0]    out_data;
   logic [7:0]     out_chan;
   logic [2:0]     out_idx;
   logic           out_last;
   logic           busy;
   logic [15:0]    scan_count;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]  sel_p0 = '0, sel_p1 = '0, sel_p2 = '0;
   logic [31:0] noise = '0;

   always #5 clk_adc = ~clk_adc;

   hist_readout_sched #(.NCH(NCH), .NWORDS(NW), .RD_LAT(RL)) dut (
      .clk_adc     (clk_adc),
      .rst         (rst),
      .scan_start  (scan_start),
      .clear_start (clear_start),
      .auto_en     (auto_en),
      .auto_period (auto_period),
      .hist_sel    (hist_sel),
      .hist_in     (hist_in),
      .resethist   (resethist),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_chan    (out_chan),
      .out_idx     (out_idx),
      .out_last    (out_last),
      .busy        (busy),
      .scan_count  (scan_count)
   );

   // Histogram array: select reaches the data RL cycles later; live counts
   // get scrambled while streaming so a non-snapshot path shows up.
   always @(posedge clk_adc) begin
      sel_p0 <= hist_sel;
      sel_p1 <= sel_p0;
      sel_p2 <= sel_p1;
      noise  <= $urandom;
   end

   always_comb begin
      hist_in = '0;
      for (int k = 0; k < NW; k++) begin
         hist_in[32*k +: 32] = (32'(sel_p2) * 32'd16 + 32'(k)) ^
                               (out_valid ? {noise[15:0], 16'h0000} : 32'h0);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic stream_word_t exp_word(input int n);
      stream_word_t w;
      w.chan = 8'(n / NW);
      w.idx  = 3'(n % NW);
      w.data = 32'(n / NW) * 32'd16 + 32'(n % NW);
      w.last = (n == TOTAL - 1);
      return w;
   endfunction

   task automatic wait_first_valid(input int exp_lat);
      int lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk_adc);
         lat++;
      end
      chk("first_valid_latency", lat, exp_lat);
   endtask

   // Consumes one full scan; returns at the negedge right after the last transfer.
   task automatic run_scan(input bit rnd, input int inj1, input int inj2);
      int n = 0;
      int cyc = 0;
      bit held_v = 1'b0, d1 = 1'b0, d2 = 1'b0;
      stream_word_t held, cur;
      held = '0;
      while (n < TOTAL && cyc < 30000) begin
         scan_start = 1'b0;
         if (!d1 && inj1 >= 0 && n >= inj1) begin
            scan_start = 1'b1;
            d1 = 1'b1;
         end else if (!d2 && inj2 >= 0 && n >= inj2) begin
            scan_start = 1'b1;
            d2 = 1'b1;
         end
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         cur.data = out_data;
         cur.chan = out_chan;
         cur.idx  = out_idx;
         cur.last = out_last;
         if (out_valid) begin
            if (held_v) chk("stall_stable", cur, held);
            if (out_ready) begin
               chk($sformatf("word%0d", n), cur, exp_word(n));
               n++;
               held_v = 1'b0;
            end else begin
               held   = cur;
               held_v = 1'b1;
            end
         end else if (held_v) begin
            chk("valid_dropped", out_valid, 1);
         end
         @(negedge clk_adc);
         cyc++;
      end
      scan_start = 1'b0;
      out_ready  = 1'b1;
      chk("scan_word_total", n, TOTAL);
   endtask

   task automatic check_clear();
      int cyc = 0;
      int nr = 0;
      bit seen_valid = 1'b0, started = 1'b0;
      while (cyc < 1000 && !(started && !resethist)) begin
         if (resethist) begin
            started = 1'b1;
            chk("clr_sel", hist_sel, nr / RL);
            nr++;
         end
         if (out_valid) seen_valid = 1'b1;
         @(negedge clk_adc);
         cyc++;
      end
      chk("clr_high_cycles", nr, NCH * RL);
      chk("clr_no_valid", seen_valid, 0);
   endtask

   initial begin
      int cyc;
      int rises;
      int n;
      int rise_at[3];
      bit prev_busy;
      bit saw_busy;

      rst = 1'b1; scan_start = 1'b0; clear_start = 1'b0;
      auto_en = 1'b0; auto_period = '0; out_ready = 1'b1;
      rise_at = '{0, 0, 0};
      repeat (3) @(negedge clk_adc);
      chk("rst_hist_sel", hist_sel, 0);
      chk("rst_resethist", resethist, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_scan_count", scan_count, 0);
      rst = 1'b0;
      @(negedge clk_adc);

      // Full scan with ready held high
      scan_start = 1'b1;
      @(negedge clk_adc);
      scan_start = 1'b0;
      wait_first_valid(RL + 2);
      run_scan(1'b0, -1, -1);
      chk("done_busy", busy, 1);
      @(negedge clk_adc);
      chk("idle_busy", busy, 0);
      chk("idle_hist_sel", hist_sel, 0);
      chk("idle_out_valid", out_valid, 0);
      chk("scan_count_1", scan_count, 1);

      // Scan with random backpressure
      repeat (5) @(negedge clk_adc);
      scan_start = 1'b1;
      @(negedge clk_adc);
      scan_start = 1'b0;
      run_scan(1'b1, -1, -1);
      @(negedge clk_adc);
      chk("scan_count_2", scan_count, 2);
      chk("stall_idle_busy", busy, 0);

      // Full clear
      repeat (3) @(negedge clk_adc);
      clear_start = 1'b1;
      @(negedge clk_adc);
      clear_start = 1'b0;
      check_clear();
      chk("clr_idle_busy", busy, 0);
      chk("clr_scan_count", scan_count, 2);

      // Simultaneous requests, then extra scan requests mid-scan
      repeat (3) @(negedge clk_adc);
      scan_start = 1'b1;
      clear_start = 1'b1;
      @(negedge clk_adc);
      scan_start = 1'b0;
      clear_start = 1'b0;
      chk("both_clear_first", resethist, 1);
      check_clear();
      run_scan(1'b0, 50, 300);
      run_scan(1'b0, -1, -1);
      @(negedge clk_adc);
      chk("scan_count_4", scan_count, 4);
      saw_busy = 1'b0;
      repeat (1000) begin
         @(negedge clk_adc);
         if (busy) saw_busy = 1'b1;
      end
      chk("third_req_dropped", saw_busy, 0);

      // Auto-scan every 2000 cycles
      auto_period = 32'd2000;
      auto_en = 1'b1;
      cyc = 0; rises = 0; prev_busy = 1'b0;
      while (rises < 3 && cyc < 8000) begin
         @(negedge clk_adc);
         cyc++;
         if (busy && !prev_busy) begin
            rise_at[rises] = cyc;
            rises++;
         end
         prev_busy = busy;
      end
      auto_en = 1'b0;
      chk("auto_rises", rises, 3);
      chk("auto_first_start", rise_at[0], 2001);
      chk("auto_interval_1", rise_at[1] - rise_at[0], 2000);
      chk("auto_interval_2", rise_at[2] - rise_at[1], 2000);
      cyc = 0;
      while (busy && cyc < 2000) begin
         @(negedge clk_adc);
         cyc++;
      end
      chk("auto_scan_count", scan_count, 7);

      // Reset in the middle of a scan
      scan_start = 1'b1;
      @(negedge clk_adc);
      scan_start = 1'b0;
      n = 0; cyc = 0;
      while (n < 100 && cyc < 5000) begin
         if (out_valid) n++;
         @(negedge clk_adc);
         cyc++;
      end
      chk("abort_words_seen", n, 100);
      rst = 1'b1;
      @(negedge clk_adc);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_hist_sel", hist_sel, 0);
      chk("abort_resethist", resethist, 0);
      chk("abort_out_last", out_last, 0);
      chk("abort_scan_count", scan_count, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk_adc);
      chk("abort_no_restart", busy, 0);
      scan_start = 1'b1;
      @(negedge clk_adc);
      scan_start = 1'b0;
      wait_first_valid(RL + 2);
      run_scan(1'b0, -1, -1);
      @(negedge clk_adc);
      chk("restart_scan_count", scan_count, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
